// File: rtl/mem_stage_if.sv
`default_nettype none
// =============================================================================
// mem_stage_if : pipeline, control and data-memory bundle for mem_stage, rev 1.0
// =============================================================================
interface mem_stage_if;
    logic         cancel;
    logic [127:0] MEM_IN;
    logic [4:0]   MEM_IN_EXC;
    logic         MEM_IN_DELAY;
    logic         MEM_over;
    logic         MEM_allow_in;
    logic         WB_allow_in;
    logic         dm_req;
    logic         dm_wr;
    logic [31:0]  dm_addr;
    logic [3:0]   dm_wstrb;
    logic [31:0]  dm_wdata;
    logic         dm_ack;
    logic [31:0]  dm_rdata;
    logic [127:0] MEM_OUT;
    logic [6:0]   MEM_OUT_EXC;
    logic         MEM_OUT_DELAY;

    // Environment side: upstream stage, commit logic, writeback and data memory.
    modport master (
        output cancel, MEM_IN, MEM_IN_EXC, MEM_IN_DELAY, WB_allow_in, dm_ack, dm_rdata,
        input  MEM_over, MEM_allow_in, dm_req, dm_wr, dm_addr, dm_wstrb, dm_wdata,
               MEM_OUT, MEM_OUT_EXC, MEM_OUT_DELAY
    );

    modport slave (
        input  cancel, MEM_IN, MEM_IN_EXC, MEM_IN_DELAY, WB_allow_in, dm_ack, dm_rdata,
        output MEM_over, MEM_allow_in, dm_req, dm_wr, dm_addr, dm_wstrb, dm_wdata,
               MEM_OUT, MEM_OUT_EXC, MEM_OUT_DELAY
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// =============================================================================
// mem_stage : pipeline memory stage with data-memory req/ack handshake, rev 1.0
// =============================================================================
module mem_stage (
    input  wire        clk,
    input  wire        reset,
    mem_stage_if.slave bus
);
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] mdr;

    logic [31:0] ir;
    logic [31:0] pc4;
    logic [31:0] ao;
    logic [31:0] rt;
    logic [5:0]  opcode;
    logic        valid;
    logic        is_lb, is_lh, is_lw, is_lbu, is_lhu;
    logic        is_sb, is_sh, is_sw;
    logic        is_load;
    logic        is_store;
    logic        ad_el;
    logic        ad_es;
    logic        access_ok;
    logic        issue;
    logic        stage_over;
    logic        stalled;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [3:0]  wstrb;
    logic [31:0] wdata;

    assign {ir, pc4, ao, rt} = bus.MEM_IN;
    assign opcode = ir[31:26];
    assign valid  = (ir != 32'd0);

    assign is_lb  = (opcode == OP_LB);
    assign is_lh  = (opcode == OP_LH);
    assign is_lw  = (opcode == OP_LW);
    assign is_lbu = (opcode == OP_LBU);
    assign is_lhu = (opcode == OP_LHU);
    assign is_sb  = (opcode == OP_SB);
    assign is_sh  = (opcode == OP_SH);
    assign is_sw  = (opcode == OP_SW);

    assign is_load  = is_lb | is_lh | is_lw | is_lbu | is_lhu;
    assign is_store = is_sb | is_sh | is_sw;

    assign ad_el = ((is_lh | is_lhu) & ao[0]) | (is_lw & (ao[1:0] != 2'b00));
    assign ad_es = (is_sh & ao[0]) | (is_sw & (ao[1:0] != 2'b00));

    // Any upstream or address exception turns the instruction into a pass-through.
    assign access_ok = valid & (is_load | is_store) & (bus.MEM_IN_EXC == 5'd0) & ~ad_el & ~ad_es;
    assign issue     = (state == S_IDLE) & access_ok & ~bus.cancel;

    always_comb begin
        case (ao[1:0])
            2'd0:    rd_byte = bus.dm_rdata[7:0];
            2'd1:    rd_byte = bus.dm_rdata[15:8];
            2'd2:    rd_byte = bus.dm_rdata[23:16];
            default: rd_byte = bus.dm_rdata[31:24];
        endcase
        rd_half  = ao[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
        load_val = 32'd0;
        if (is_lb)
            load_val = {{24{rd_byte[7]}}, rd_byte};
        else if (is_lbu)
            load_val = {24'd0, rd_byte};
        else if (is_lh)
            load_val = {{16{rd_half[15]}}, rd_half};
        else if (is_lhu)
            load_val = {16'd0, rd_half};
        else if (is_lw)
            load_val = bus.dm_rdata;
    end

    always_comb begin
        wstrb = 4'b0000;
        wdata = rt;
        if (is_sw) begin
            wstrb = 4'b1111;
            wdata = rt;
        end else if (is_sh) begin
            wstrb = 4'b0011 << ao[1:0];
            wdata = {2{rt[15:0]}};
        end else if (is_sb) begin
            wstrb = 4'b0001 << ao[1:0];
            wdata = {4{rt[7:0]}};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            mdr   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        if (bus.dm_ack) begin
                            state <= S_DONE;
                            mdr   <= load_val;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A flush that coincides with the ack has nothing left to drain.
                    if (bus.dm_ack) begin
                        if (bus.cancel) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_DONE;
                            mdr   <= load_val;
                        end
                    end else if (bus.cancel) begin
                        state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (bus.WB_allow_in || bus.cancel)
                        state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (bus.dm_ack)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stalled    = (state == S_WAIT) | (state == S_DRAIN);
    assign stage_over = reset & (((state == S_IDLE) & valid & ~access_ok) | (state == S_DONE));

    assign bus.MEM_over     = stage_over;
    assign bus.MEM_allow_in = ~stalled & (~valid | (stage_over & bus.WB_allow_in));

    // The request is gated by reset so an in-flight access is dropped immediately.
    assign bus.dm_req   = reset & (issue | (state == S_WAIT));
    assign bus.dm_wr    = is_store;
    assign bus.dm_addr  = {ao[31:2], 2'b00};
    assign bus.dm_wstrb = wstrb;
    assign bus.dm_wdata = wdata;

    assign bus.MEM_OUT       = {ir, pc4, ao, (is_load ? mdr : 32'd0)};
    assign bus.MEM_OUT_EXC   = {ad_es, ad_el, bus.MEM_IN_EXC};
    assign bus.MEM_OUT_DELAY = bus.MEM_IN_DELAY;
endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port cancel, input, 1, exception flush from commit logic.
REQ-004 SHALL have port MEM_IN, input, 128: [127:96] IR, [95:64] PC4, [63:32] AO (address/ALU result), [31:0] RT (store data).
REQ-005 SHALL have ports MEM_IN_EXC (input, 5, {ovf, reserved-instr, break, syscall, fetch-addr}) and MEM_IN_DELAY (input, 1, delay-slot flag).
REQ-006 SHALL have ports MEM_over (output, 1, stage result valid) and MEM_allow_in (output, 1, upstream may load next instruction).
REQ-007 SHALL have port WB_allow_in, input, 1, downstream accepts this cycle.
REQ-008 SHALL have data-memory ports dm_req (out 1), dm_wr (out 1), dm_addr (out 32), dm_wstrb (out 4), dm_wdata (out 32), dm_ack (in 1), dm_rdata (in 32).
REQ-009 SHALL have outputs MEM_OUT (128: {IR, PC4, AO, MDR}), MEM_OUT_EXC (7: {AdES, AdEL, MEM_IN_EXC}), MEM_OUT_DELAY (1).

Function
REQ-010 SHALL treat IR==0 as a bubble (not valid); all other IR values are valid.
REQ-011 SHALL decode loads LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101 and stores SB 101000, SH 101001, SW 101011 from IR[31:26]; all other opcodes are non-memory.
REQ-012 SHALL raise AdEL for LH/LHU with AO[0]=1 or LW with AO[1:0]!=0, and AdES for SH with AO[0]=1 or SW with AO[1:0]!=0.
REQ-013 SHALL issue an access only for a valid memory instruction with MEM_IN_EXC==0, AdEL==0, AdES==0, and cancel==0.
REQ-014 SHALL implement FSM states IDLE, WAIT, DONE, DRAIN.
REQ-015 IDLE: access qualifies -> dm_req=1; dm_ack same cycle -> DONE, else -> WAIT; non-qualifying valid instruction -> MEM_over=1 combinationally, state stays IDLE.
REQ-016 WAIT: dm_req held high with stable dm_addr/dm_wr/dm_wstrb/dm_wdata; dm_ack -> DONE; cancel without ack -> DRAIN.
REQ-017 DONE: MEM_over=1; WB_allow_in=1 or cancel=1 -> IDLE.
REQ-018 DRAIN: dm_req=0, MEM_over=0, MEM_allow_in=0; dm_ack -> IDLE, read data discarded.
REQ-019 SHALL drive MEM_allow_in = ~valid | (MEM_over & WB_allow_in), forced 0 in WAIT and DRAIN.
REQ-020 SHALL drive dm_addr = {AO[31:2], 2'b00}, dm_wr=1 for stores.
REQ-021 Store strobes/data (little-endian): SW -> 4'b1111, RT; SH -> 4'b0011<<AO[1:0], {2{RT[15:0]}}; SB -> 4'b0001<<AO[1:0], {4{RT[7:0]}}; loads drive dm_wstrb=0.
REQ-022 SHALL latch MDR on dm_ack for loads: byte/half selected by AO[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word; MDR=0 for stores and non-memory instructions.
REQ-023 SHALL pass IR, PC4, AO, MEM_IN_EXC, and MEM_IN_DELAY through to outputs unchanged, combinationally from MEM_IN.
REQ-024 SHALL accept dm_ack only in IDLE (when requesting), WAIT, and DRAIN; dm_ack in other states SHALL be ignored.
REQ-025 On cancel in IDLE or DONE, SHALL suppress dm_req that cycle and return to IDLE.

Reset
REQ-026 On reset=0, SHALL asynchronously force state=IDLE and MDR=0; dm_req=0 and MEM_over=0 while reset is asserted.
REQ-027 SHALL keep dm_req low during reset even if an access was outstanding; the system resets the memory concurrently.

Verification
REQ-028 Bench SHALL cover: LW AO=0x100, dm_rdata=0x12345678, ack after 2 cycles, WB_allow_in=1 -> dm_req high 3 cycles, MDR=0x12345678, MEM_over high in DONE.
REQ-029 Bench SHALL cover: LB AO=0x103, rdata=0x80FFFFFF -> MDR=0xFFFFFF80; LBU same -> MDR=0x00000080.
REQ-030 Bench SHALL cover: SH AO=0x102, RT=0x0000ABCD -> dm_wstrb=4'b1100, dm_wdata=0xABCDABCD, dm_wr=1.
REQ-031 Bench SHALL cover: SW AO=0x101 -> no dm_req, MEM_OUT_EXC[6]=1, MEM_over=1 the same cycle.
REQ-032 Bench SHALL cover: LW in WAIT, cancel pulse, ack 3 cycles later -> DRAIN, MEM_allow_in=0 until ack, then IDLE, MDR unchanged.
REQ-033 Bench SHALL cover: LW in DONE with WB_allow_in=0 for 4 cycles -> MEM_over held 1, MEM_allow_in=0, MEM_OUT stable; reset mid-WAIT -> IDLE, dm_req=0 immediately.
